// File: rtl/button_debouncer_if.sv
// button_debouncer_if: raw pin in, clean level and edge pulses out.
// master = debouncer side, slave = consuming logic / stimulus side.
interface button_debouncer_if;
    logic btn_in;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;
    logic busy;

    modport master (
        input  btn_in,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output busy
    );

    modport slave (
        output btn_in,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  busy
    );
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises a bouncing pin and qualifies each
// level change over CNT_MAX stable cycles before reporting it.
module button_debouncer #(
    parameter int CNT_MAX     = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input logic                clk,
    input logic                reset,
    button_debouncer_if.master bus
);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_HIGH,
        S_HIGH,
        S_WAIT_LOW
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_n;
    logic                   level_n;
    logic                   rise_n;
    logic                   fall_n;
    logic                   busy_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], bus.btn_in};
        end
    end

    assign sync_q = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_LOW;
            cnt           <= '0;
            bus.btn_level <= 1'b0;
            bus.btn_rise  <= 1'b0;
            bus.btn_fall  <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bus.btn_level <= level_n;
            bus.btn_rise  <= rise_n;
            bus.btn_fall  <= fall_n;
            bus.busy      <= busy_n;
        end
    end

    // Any return to the old level during WAIT drops the candidate entirely
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        level_n = bus.btn_level;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        unique case (state)
            S_LOW: begin
                if (sync_q) begin
                    state_n = S_WAIT_HIGH;
                    cnt_n   = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!sync_q) begin
                    state_n = S_LOW;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = S_HIGH;
                    level_n = 1'b1;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_HIGH: begin
                if (!sync_q) begin
                    state_n = S_WAIT_LOW;
                    cnt_n   = '0;
                end
            end
            S_WAIT_LOW: begin
                if (sync_q) begin
                    state_n = S_HIGH;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = S_LOW;
                    level_n = 1'b0;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_LOW;
                cnt_n   = '0;
            end
        endcase
        busy_n = (state_n == S_WAIT_HIGH) || (state_n == S_WAIT_LOW);
    end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: pulse scoreboard for CNT_MAX=4 and CNT_MAX=1
// instances, plus level/busy spot checks.
module tb_button_debouncer;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    typedef struct {
        bit rise;
        int at;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];

    button_debouncer_if bif_a ();
    button_debouncer_if bif_b ();

    button_debouncer #(
        .CNT_MAX    (4),
        .SYNC_STAGES(2)
    ) dut_a (
        .clk  (clk),
        .reset(rst_a),
        .bus  (bif_a.master)
    );

    button_debouncer #(
        .CNT_MAX    (1),
        .SYNC_STAGES(2)
    ) dut_b (
        .clk  (clk),
        .reset(rst_b),
        .bus  (bif_b.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    // dly counts from the current negedge: input edge is cyc+1
    task automatic expect_a(bit r, int dly);
        q_a.push_back(ev_t'{rise: r, at: cyc + dly});
    endtask

    task automatic expect_b(bit r, int dly);
        q_b.push_back(ev_t'{rise: r, at: cyc + dly});
    endtask

    always @(negedge clk) begin : mon_a
        ev_t ev;
        if (bif_a.btn_rise || bif_a.btn_fall) begin
            check("a_excl", int'(bif_a.btn_rise & bif_a.btn_fall), 0);
            if (q_a.size() == 0) begin
                check("a_unexpected_pulse_cyc", cyc, -1);
            end else begin
                ev = q_a.pop_front();
                check("a_kind", int'(bif_a.btn_rise), int'(ev.rise));
                check("a_cycle", cyc, ev.at);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        ev_t ev;
        if (bif_b.btn_rise || bif_b.btn_fall) begin
            check("b_excl", int'(bif_b.btn_rise & bif_b.btn_fall), 0);
            if (q_b.size() == 0) begin
                check("b_unexpected_pulse_cyc", cyc, -1);
            end else begin
                ev = q_b.pop_front();
                check("b_kind", int'(bif_b.btn_rise), int'(ev.rise));
                check("b_cycle", cyc, ev.at);
            end
        end
    end

    task automatic clean_a(bit v);
        bif_a.btn_in = v;
        expect_a(v, 7);
        tick(6);
        check("a_clean_level_before", int'(bif_a.btn_level), int'(!v));
        tick(1);
        check("a_clean_level_after", int'(bif_a.btn_level), int'(v));
        check("a_clean_busy_after", int'(bif_a.busy), 0);
        tick(12);
    endtask

    initial begin
        bit pat[16];
        int exp_busy;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bif_a.btn_in = 1'b1;
        bif_b.btn_in = 1'b0;
        tick(3);
        check("a_rst_level", int'(bif_a.btn_level), 0);
        check("a_rst_rise", int'(bif_a.btn_rise), 0);
        check("a_rst_fall", int'(bif_a.btn_fall), 0);
        check("a_rst_busy", int'(bif_a.busy), 0);
        check("b_rst_level", int'(bif_b.btn_level), 0);

        // held-high input qualifies straight out of reset
        rst_a = 1'b0;
        rst_b = 1'b0;
        expect_a(1'b1, 7);
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            check("a_post_rst_busy", int'(bif_a.busy), int'(k >= 3 && k <= 6));
        end
        check("a_post_rst_level", int'(bif_a.btn_level), 1);
        tick(5);

        clean_a(1'b0);
        clean_a(1'b1);
        tick(20);
        clean_a(1'b0);

        pat = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 16; i++) begin
            bif_a.btn_in = pat[i];
            tick(1);
            exp_busy = 0;
            if (i >= 2) exp_busy = int'(pat[i-2]);
            check("a_bounce_busy", int'(bif_a.busy), exp_busy);
        end
        check("a_bounce_level", int'(bif_a.btn_level), 0);
        check("a_bounce_queue", q_a.size(), 0);

        pat = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        for (int i = 0; i < 16; i++) begin
            bif_a.btn_in = pat[i];
            if (i == 3) expect_a(1'b1, 7);
            tick(1);
        end
        check("a_settle_level", int'(bif_a.btn_level), 1);
        check("a_settle_queue", q_a.size(), 0);

        bif_a.btn_in = 1'b0;
        tick(3);
        check("a_midq_busy", int'(bif_a.busy), 1);
        check("a_midq_level", int'(bif_a.btn_level), 1);
        #1;
        rst_a = 1'b1;
        bif_a.btn_in = 1'b1;
        #1;
        check("a_midq_rst_level", int'(bif_a.btn_level), 0);
        check("a_midq_rst_busy", int'(bif_a.busy), 0);
        tick(1);
        rst_a = 1'b0;
        expect_a(1'b1, 7);
        tick(9);
        check("a_midq_requal_level", int'(bif_a.btn_level), 1);

        #1;
        rst_a = 1'b1;
        #1;
        check("a_high_rst_level", int'(bif_a.btn_level), 0);
        tick(1);
        rst_a = 1'b0;
        expect_a(1'b1, 7);
        tick(9);
        check("a_high_requal_level", int'(bif_a.btn_level), 1);

        bif_b.btn_in = 1'b1;
        expect_b(1'b1, 4);
        tick(3);
        check("b_press_level_before", int'(bif_b.btn_level), 0);
        check("b_press_busy", int'(bif_b.busy), 1);
        tick(1);
        check("b_press_level_after", int'(bif_b.btn_level), 1);
        tick(4);
        bif_b.btn_in = 1'b0;
        expect_b(1'b0, 4);
        tick(2);
        bif_b.btn_in = 1'b1;
        expect_b(1'b1, 4);
        tick(2);
        check("b_glitch_level_low", int'(bif_b.btn_level), 0);
        tick(2);
        check("b_glitch_level_high", int'(bif_b.btn_level), 1);

        tick(6);
        check("a_final_queue", q_a.size(), 0);
        check("b_final_queue", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
